// File: rtl/gcd_pkg.sv
// rtl/gcd_pkg.sv - shared state encoding and data width for the GCD scheduler
package gcd_pkg;

    localparam int GCD_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting after the last grant
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int REQ_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [REQ_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [REQ_W-1:0]   index,
    output logic               any
);

    // Walk the requesters from last_grant+1, wrapping, and keep the first asserted one
    always_comb begin
        int idx;
        grant = '0;
        index = '0;
        any   = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_grant) + k) % NUM_REQ;
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                index      = REQ_W'(idx);
            end
        end
    end

endmodule

// File: rtl/gcd_scheduler.sv
// rtl/gcd_scheduler.sv - round-robin sharing of one GCD core between requesters
module gcd_scheduler
    import gcd_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int REQ_W   = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic                     HCLK,
    input  logic                     HRESET,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*GCD_W-1:0] req_a,
    input  logic [NUM_REQ*GCD_W-1:0] req_b,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic [GCD_W-1:0]         rsp_result,
    output logic                     rsp_err,
    output logic                     gcd_start,
    output logic [GCD_W-1:0]         gcd_a,
    output logic [GCD_W-1:0]         gcd_b,
    input  logic [GCD_W-1:0]         gcd_result,
    input  logic                     gcd_done,
    output logic                     busy,
    output logic [REQ_W-1:0]         grant_id
);

    localparam int                TMR_W    = $clog2(TIMEOUT);
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT - 1);

    state_t              state;
    state_t              state_nxt;
    logic [TMR_W-1:0]    timer;
    logic [REQ_W-1:0]    last_grant;
    logic [REQ_W-1:0]    arb_idx;
    logic [NUM_REQ-1:0]  arb_grant;
    logic                arb_any;
    logic [GCD_W-1:0]    sel_a;
    logic [GCD_W-1:0]    sel_b;
    logic                sel_zero;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .REQ_W   (REQ_W)
    ) u_arb (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (arb_grant),
        .index      (arb_idx),
        .any        (arb_any)
    );

    assign sel_a    = req_a[int'(arb_idx)*GCD_W +: GCD_W];
    assign sel_b    = req_b[int'(arb_idx)*GCD_W +: GCD_W];
    assign sel_zero = (sel_a == '0) || (sel_b == '0);

    // State register
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and state-decoded outputs
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        rsp_valid = '0;
        gcd_start = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                req_ready = arb_grant;
                if (arb_any) begin
                    state_nxt = sel_zero ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                gcd_start = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (gcd_done || (timer == TMR_LAST)) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid[grant_id] = 1'b1;
                state_nxt           = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, grant tracking, timeout timer and result registers
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            gcd_a      <= '0;
            gcd_b      <= '0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
            grant_id   <= '0;
            last_grant <= REQ_W'(NUM_REQ - 1);
            timer      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_any) begin
                        gcd_a      <= sel_a;
                        gcd_b      <= sel_b;
                        grant_id   <= arb_idx;
                        last_grant <= arb_idx;
                        if (sel_zero) begin
                            rsp_result <= sel_a | sel_b;
                            rsp_err    <= 1'b0;
                        end
                    end
                end
                ISSUE: begin
                    timer <= '0;
                end
                WAIT: begin
                    timer <= timer + TMR_W'(1);
                    if (gcd_done) begin
                        rsp_result <= gcd_result;
                        rsp_err    <= 1'b0;
                    end else if (timer == TMR_LAST) begin
                        rsp_result <= '0;
                        rsp_err    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
